fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of instr_mem. Owns the fetch PC and drives the ROM byte address. Captures the combinational 32-bit instruction word into a small in-order prefetch buffer. Presents fetched instructions to decode with a valid/ready handshake, and accepts a one-cycle redirect (branch/jump) that flushes the buffer.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-buffer entry type for the instruction-fetch stage.
package fetch_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [AW-1:0] RESET_PC  = 32'hBFC00000;
  localparam logic [AW-1:0] ROM_LIMIT = 32'hBFC00FFF;
  localparam logic [DW-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of fetch entries; flush beats push, push+pop while full is allowed.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop, clr;

  assign clr     = rst | flush;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & ~clr & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty masks stale entries at the outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, drives instr_mem, buffers words for decode, handles redirects.
module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH         = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = fetch_pkg::RESET_PC,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_LIMIT     = fetch_pkg::ROM_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDRESS_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]      imem_rd,
  input  logic                       redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DATA_WIDTH-1:0]      instr,
  output logic [ADDRESS_WIDTH-1:0]   instr_pc,
  output logic                       instr_fault,
  output logic [$clog2(DEPTH):0]     count
);
  import fetch_pkg::*;

  logic [ADDRESS_WIDTH-1:0] fpc;
  logic [ADDRESS_WIDTH:0]   fpc_x;
  logic                     fault, pop, fetch_en, full, empty;
  fetch_entry_t             din, head;

  assign imem_addr = fpc;
  assign pop       = instr_valid & instr_ready;
  assign fetch_en  = ~redirect_valid & (~full | pop);

  // One extra bit so fpc+3 near the top of the address space cannot wrap past the limit check.
  assign fpc_x = {1'b0, fpc};
  assign fault = (fpc[1:0] != 2'b00)
               | (fpc_x < {1'b0, RESET_PC})
               | ((fpc_x + (ADDRESS_WIDTH+1)'(3)) > {1'b0, ROM_LIMIT});

  always_comb begin
    din       = '0;
    din.pc    = fpc;
    din.fault = fault;
    din.instr = fault ? NOP_INSTR : imem_rd;
  end

  always_ff @(posedge clk) begin
    if (rst)                 fpc <= RESET_PC;
    else if (redirect_valid) fpc <= redirect_pc;
    else if (fetch_en)       fpc <= fpc + ADDRESS_WIDTH'(4);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign instr_valid = ~empty;
  assign instr       = empty ? NOP_INSTR : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;
  assign instr_fault = ~empty & head.fault;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, ROM-edge/misaligned/wrap faults, reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, redirect_valid, instr_ready;
  logic [31:0] imem_addr, imem_rd, redirect_pc, instr, instr_pc;
  logic        instr_valid, instr_fault;
  logic [1:0]  count;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] W0 = 32'h11110001, W1 = 32'h22220002,
                          W2 = 32'h33330003, W3 = 32'h44440004;
  localparam logic [31:0] NOP = 32'h00000013;

  always #5 clk = ~clk;

  // ROM: four fixed words at the base, elsewhere addr ^ 5A5A5A5A.
  always_comb begin
    case (imem_addr)
      32'hBFC00000: imem_rd = W0;
      32'hBFC00004: imem_rd = W1;
      32'hBFC00008: imem_rd = W2;
      32'hBFC0000C: imem_rd = W3;
      default:      imem_rd = imem_addr ^ 32'h5A5A5A5A;
    endcase
  end

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault), .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    step(); step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
    checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", instr_fault); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (imem_addr !== 32'hBFC00000) begin errors++; $display("FAIL reset_addr got %h exp BFC00000", imem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] w [4];
    w[0] = W0; w[1] = W1; w[2] = W2; w[3] = W3;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (instr !== w[i]) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr, w[i]); end
      checks++; if (instr_pc !== 32'hBFC00000 + 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, instr_pc, 32'hBFC00000 + 32'(4*i)); end
      checks++; if (imem_addr !== 32'hBFC00004 + 32'(4*i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, 32'hBFC00004 + 32'(4*i)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w [3];
    w[0] = W0; w[1] = W1; w[2] = W2;
    rst = 1'b1; step(); rst = 1'b0; instr_ready = 1'b0;
    repeat (5) step();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", count); end
    checks++; if (imem_addr !== 32'hBFC00008) begin errors++; $display("FAIL stall_addr got %h exp BFC00008", imem_addr); end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== w[i] || instr_pc !== 32'hBFC00000 + 32'(4*i))
        begin errors++; $display("FAIL stall_drain[%0d] got %b/%h/%h exp 1/%h/%h", i, instr_valid, instr, instr_pc, w[i], 32'hBFC00000 + 32'(4*i)); end
      step();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0; step(); step();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL redir_prefill got %0d exp 2", count); end
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00100;
    step();
    redirect_valid = 1'b0;
    checks++; if (count !== 2'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got count=%0d valid=%b exp 0/0", count, instr_valid); end
    checks++; if (imem_addr !== 32'hBFC00100) begin errors++; $display("FAIL redir_addr got %h exp BFC00100", imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hBFC00100 || instr !== 32'hE59A5B5A)
      begin errors++; $display("FAIL redir_first got %b/%h/%h exp 1/BFC00100/E59A5B5A", instr_valid, instr_pc, instr); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL redir_count got %0d exp 1", count); end
  endtask

  task automatic test_rom_end();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hBFC00FFC;
    step(); redirect_valid = 1'b0; step();
    checks++; if (instr_pc !== 32'hBFC00FFC || instr_fault !== 1'b0 || instr !== 32'hE59A55A6)
      begin errors++; $display("FAIL romend_last got %h/%b/%h exp BFC00FFC/0/E59A55A6", instr_pc, instr_fault, instr); end
    step();
    checks++; if (instr_pc !== 32'hBFC01000 || instr_fault !== 1'b1 || instr !== NOP)
      begin errors++; $display("FAIL romend_past got %h/%b/%h exp BFC01000/1/00000013", instr_pc, instr_fault, instr); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00002;
    step(); redirect_valid = 1'b0; step();
    checks++; if (instr_pc !== 32'hBFC00002 || instr_fault !== 1'b1 || instr !== NOP)
      begin errors++; $display("FAIL misal_first got %h/%b/%h exp BFC00002/1/00000013", instr_pc, instr_fault, instr); end
    step();
    checks++; if (instr_pc !== 32'hBFC00006 || instr_fault !== 1'b1 || instr !== NOP)
      begin errors++; $display("FAIL misal_next got %h/%b/%h exp BFC00006/1/00000013", instr_pc, instr_fault, instr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step(); redirect_valid = 1'b0; step();
    checks++; if (instr_pc !== 32'hFFFFFFFC || instr_fault !== 1'b1)
      begin errors++; $display("FAIL wrap_top got %h/%b exp FFFFFFFC/1", instr_pc, instr_fault); end
    step();
    checks++; if (instr_pc !== 32'h0 || instr_fault !== 1'b1 || instr !== NOP || instr_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_zero got %b/%h/%b/%h exp 1/00000000/1/00000013", instr_valid, instr_pc, instr_fault, instr); end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00000; step();
    redirect_valid = 1'b0; instr_ready = 1'b0; step(); step();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL rstmid_prefill got %0d exp 2", count); end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hBFC00100;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || count !== 2'd0 || imem_addr !== 32'hBFC00000)
      begin errors++; $display("FAIL rstmid_state got %b/%0d/%h exp 0/0/BFC00000", instr_valid, count, imem_addr); end
    instr_ready = 1'b1;
    step();
    checks++; if (instr !== W0 || instr_pc !== 32'hBFC00000) begin errors++; $display("FAIL rstmid_w0 got %h/%h exp %h/BFC00000", instr, instr_pc, W0); end
    step();
    checks++; if (instr !== W1 || instr_pc !== 32'hBFC00004) begin errors++; $display("FAIL rstmid_w1 got %h/%h exp %h/BFC00004", instr, instr_pc, W1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_rom_end();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
